msu_result_resolver: RTL and testbench

//  Consumes the redundant-form squarer result bus: NUM_ELEMENTS coefficients, each in a 32-bit lane.

---
 rtl/msu_result_resolver.sv | 141 ++++++++++++++
 tb/tb_msu_result_resolver.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/msu_result_resolver.sv
// Carry-resolves the redundant squarer output (one coefficient per 32-bit lane) into a
// single non-redundant integer, ELEMS_PER_CYCLE coefficients per clock, held under valid/ready.
module msu_result_resolver #(
  parameter int MOD_LEN         = 1024,
  parameter int WORD_LEN        = 16,
  parameter int BIT_LEN         = 17,
  parameter int NUM_ELEMENTS    = MOD_LEN / WORD_LEN + 2,
  parameter int ELEMS_PER_CYCLE = 1,
  parameter int RESULT_BITS     = NUM_ELEMENTS * WORD_LEN + 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_ELEMENTS*32-1:0]  sq_out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [RESULT_BITS-1:0]      result,
  output logic                        busy,
  output logic                        fmt_err,
  output logic                        overrun
);

  localparam int IDX_W   = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;
  localparam int ACC_W   = BIT_LEN + 1;
  localparam int CARRY_W = ACC_W - WORD_LEN;

  if (NUM_ELEMENTS < MOD_LEN / WORD_LEN + 1 || NUM_ELEMENTS % ELEMS_PER_CYCLE != 0) begin : g_bad_params
    $error("msu_result_resolver: inconsistent NUM_ELEMENTS / ELEMS_PER_CYCLE");
  end

  typedef enum logic [1:0] {IDLE, RESOLVE, DONE} state_t;

  state_t                  state, state_next;
  logic [IDX_W-1:0]        idx;
  logic [CARRY_W-1:0]      carry;
  logic [RESULT_BITS-1:0]  result_q;
  logic                    fmt_err_q, overrun_q;
  logic [BIT_LEN-1:0]      coeff      [NUM_ELEMENTS];
  logic [BIT_LEN-1:0]      lane_coeff [NUM_ELEMENTS];
  logic                    lane_bad;
  logic [WORD_LEN-1:0]     step_word  [ELEMS_PER_CYCLE];
  logic [CARRY_W-1:0]      step_carry;
  logic [ACC_W-1:0]        acc;
  logic                    last_step;

  wire accept_in = (state == IDLE) && in_valid;

  // Lane split: low BIT_LEN bits are the coefficient, anything above is a format error.
  always_comb begin
    lane_bad = 1'b0;
    for (int j = 0; j < NUM_ELEMENTS; j++) begin
      lane_coeff[j] = sq_out[j*32 +: BIT_LEN];
      lane_bad      = lane_bad | (|sq_out[j*32+BIT_LEN +: 32-BIT_LEN]);
    end
  end

  // NOTE: blocking '=' here is intentional -- each loop iteration must see the carry
  // produced by the previous one within the same cycle; sequential blocks use '<='.
  always_comb begin
    step_carry = carry;
    acc        = '0;
    for (int k = 0; k < ELEMS_PER_CYCLE; k++) begin
      acc          = {1'b0, coeff[idx + IDX_W'(k)]} + ACC_W'(step_carry);
      step_word[k] = acc[WORD_LEN-1:0];
      step_carry   = acc[ACC_W-1:WORD_LEN];
    end
  end

  assign last_step = (idx == IDX_W'(NUM_ELEMENTS - ELEMS_PER_CYCLE));

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RESOLVE;
      RESOLVE: if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // NOTE: the coefficient shadow registers carry no reset; they are always reloaded on
  // capture before being read, so a reset would only cost routing.
  always_ff @(posedge clk) begin
    if (accept_in) begin
      for (int j = 0; j < NUM_ELEMENTS; j++) coeff[j] <= lane_coeff[j];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx       <= '0;
      carry     <= '0;
      result_q  <= '0;
      fmt_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (in_valid && state != IDLE) overrun_q <= 1'b1;
      case (state)
        IDLE: begin
          if (in_valid) begin
            idx   <= '0;
            carry <= '0;
            if (lane_bad) fmt_err_q <= 1'b1;
          end
        end
        RESOLVE: begin
          for (int k = 0; k < ELEMS_PER_CYCLE; k++)
            result_q[(int'(idx) + k)*WORD_LEN +: WORD_LEN] <= step_word[k];
          carry <= step_carry;
          if (last_step) begin
            result_q[RESULT_BITS-1 -: CARRY_W] <= step_carry;
            idx <= '0;
          end else begin
            idx <= idx + IDX_W'(ELEMS_PER_CYCLE);
          end
        end
        default: ;
      endcase
    end
  end

  assign result  = result_q;
  assign fmt_err = fmt_err_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_msu_result_resolver.sv
// Directed bench for msu_result_resolver: four instances (ELEMS_PER_CYCLE 1/2/3/6) at
// MOD_LEN=64; expected results come from hand constants and a positional reference sum.
`timescale 1ns/1ps
module tb_msu_result_resolver;
  localparam int MOD_LEN  = 64;
  localparam int WORD_LEN = 16;
  localparam int BIT_LEN  = 17;
  localparam int NE       = 6;
  localparam int RB       = 98;
  localparam int SQ_W     = NE * 32;
  localparam int NI       = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n;
  logic [NI-1:0]   in_valid, out_ready;
  logic [SQ_W-1:0] sq [NI];
  wire  [NI-1:0]   in_ready, out_valid, busy, fmt_err, overrun;
  wire  [RB-1:0]   result [NI];

  int n_cmp = 0;
  int n_bad = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int EPC = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 6;
    msu_result_resolver #(
      .MOD_LEN(MOD_LEN), .WORD_LEN(WORD_LEN), .BIT_LEN(BIT_LEN),
      .NUM_ELEMENTS(NE), .ELEMS_PER_CYCLE(EPC), .RESULT_BITS(RB)
    ) u_dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]), .sq_out(sq[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]), .result(result[g]),
      .busy(busy[g]), .fmt_err(fmt_err[g]), .overrun(overrun[g])
    );
  end

  function automatic int epc_of(input int m);
    case (m)
      0: return 1;
      1: return 2;
      2: return 3;
      default: return 6;
    endcase
  endfunction

  // Positional sum of the significant coefficient bits, independent of any carry chain.
  function automatic logic [RB-1:0] ref_sum(input logic [SQ_W-1:0] v);
    logic [RB-1:0] s;
    s = '0;
    for (int j = 0; j < NE; j++) s = s + (RB'(v[j*32 +: BIT_LEN]) << (WORD_LEN * j));
    return s;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int m, input logic [SQ_W-1:0] v);
    in_valid[m] = 1'b1;
    sq[m]       = v;
    tick();
    in_valid[m] = 1'b0;
  endtask

  // Latency is counted in sampling edges from the capture edge; -1 means timeout.
  task automatic wait_done(input int m, output int lat);
    int n;
    n = 0;
    while (!out_valid[m] && n < 40) begin
      tick();
      n++;
    end
    lat = out_valid[m] ? n + 1 : -1;
  endtask

  task automatic accept(input int m);
    out_ready[m] = 1'b1;
    tick();
    out_ready[m] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SQ_W-1:0] v, junk;
    logic [RB-1:0]   exp_r;
    int lat, seen;

    reset_n   = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    for (int m = 0; m < NI; m++) sq[m] = '0;
    repeat (3) tick();
    reset_n = 1'b1;

    check("rst_in_ready",  in_ready[0],  1);
    check("rst_out_valid", out_valid[0], 0);
    check("rst_busy",      busy[0],      0);
    check("rst_fmt_err",   fmt_err[0],   0);
    check("rst_overrun",   overrun[0],   0);
    check("rst_result",    result[0],    0);

    // 1: two saturated coefficients ripple a carry into word 2
    v = '0;
    v[31:0]  = 32'h0001_FFFF;
    v[63:32] = 32'h0001_FFFF;
    send(0, v);
    check("t1_busy",     busy[0],     1);
    check("t1_in_ready", in_ready[0], 0);
    wait_done(0, lat);
    check("t1_latency",  lat,         7);
    check("t1_result",   result[0],   128'h2_0000_FFFF);
    check("t1_fmt_err",  fmt_err[0],  0);
    accept(0);
    check("t1_accept_ov", out_valid[0], 0);
    check("t1_accept_ir", in_ready[0],  1);

    // 2: every lane 0x10000 -> final carry lands in bit 96
    for (int j = 0; j < NE; j++) v[j*32 +: 32] = 32'h0001_0000;
    send(0, v);
    wait_done(0, lat);
    check("t2_result", result[0],
          128'h1_0001_0001_0001_0001_0001_0000);
    check("t2_bit96",  result[0][96], 1);
    accept(0);

    // 3: result held under back-pressure; in_valid while DONE only sets overrun
    v = '0;
    v[31:0]  = 32'h0001_0000;
    v[63:32] = 32'h0000_ABCD;
    v[95:64] = 32'h0001_2345;
    exp_r = ref_sum(v);
    send(0, v);
    wait_done(0, lat);
    check("t3_overrun_before", overrun[0], 0);
    junk = {NE{32'h0000_7777}};
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        in_valid[0] = 1'b1;
        sq[0]       = junk;
      end
      tick();
      in_valid[0] = 1'b0;
    end
    check("t3_out_valid", out_valid[0], 1);
    check("t3_result",    result[0],    exp_r);
    check("t3_overrun",   overrun[0],   1);
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    sq[0]        = junk;
    tick();
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
    check("t3_acc_out_valid", out_valid[0], 0);
    check("t3_acc_in_ready",  in_ready[0],  1);
    check("t3_acc_busy",      busy[0],      0);

    // 4: reset in mid-RESOLVE (idx=3) discards the operation
    v = '0;
    v[31:0]   = 32'h0000_1234;
    v[191:160] = 32'h0001_8001;
    send(0, v);
    check("t4_taken", busy[0], 1);
    repeat (3) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("t4_busy",      busy[0],      0);
    check("t4_out_valid", out_valid[0], 0);
    check("t4_in_ready",  in_ready[0],  1);
    check("t4_overrun",   overrun[0],   0);
    check("t4_result",    result[0],    0);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (out_valid[0]) seen++;
    end
    check("t4_no_valid", seen, 0);
    send(0, v);
    wait_done(0, lat);
    check("t4_latency", lat,       7);
    check("t4_result2", result[0], ref_sum(v));
    accept(0);

    // 5: stray upper lane bit flags fmt_err and is ignored arithmetically
    v = '0;
    v[95:64] = 32'h0010_0001;
    send(0, v);
    check("t5_fmt_err", fmt_err[0], 1);
    wait_done(0, lat);
    check("t5_result",  result[0],  128'h1_0000_0000);
    accept(0);
    check("t5_fmt_sticky", fmt_err[0], 1);

    // 6: wider steps, random vectors, back-to-back with out_ready held high
    for (int m = 1; m < NI; m++) begin
      out_ready[m] = 1'b1;
      for (int r = 0; r < 2; r++) begin
        for (int j = 0; j < NE; j++) v[j*32 +: 32] = $urandom_range(0, 32'h0001_FFFF);
        check($sformatf("t6_in_ready_e%0d_%0d", epc_of(m), r), in_ready[m], 1);
        send(m, v);
        wait_done(m, lat);
        check($sformatf("t6_latency_e%0d_%0d", epc_of(m), r), lat, 1 + NE / epc_of(m));
        check($sformatf("t6_result_e%0d_%0d",  epc_of(m), r), result[m], ref_sum(v));
        tick();
        check($sformatf("t6_released_e%0d_%0d", epc_of(m), r), out_valid[m], 0);
      end
      out_ready[m] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
